pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
// - Parametrised chain of DEPTH pipeline registers, WIDTH-bit payload, per-stage valid bit.
// - Replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches with one generic block.
// - Adds what the fixed latches lack: ready/valid backpressure, bubble collapsing and per-stage flush.
// - Adds an occupancy count, used by stall/hazard logic and by the pipeline top for debug.
// PARAMETERS
// - WIDTH   32  payload bits per stage (>=1)
// - DEPTH   4   number of register stages (>=1); stage 0 = input side, stage DEPTH-1 = output
// - OCC_W   $clog2(DEPTH+1)  width of occupancy (derived; do not override)
// PORTS
// - clk         in   1          rising-edge clock; single clock domain
// - rst         in   1          synchronous, active-high reset
// - in_valid    in   1          upstream presents in_data
// - in_data     in   WIDTH      payload into stage 0
// - in_ready    out  1          stage 0 can accept this cycle (combinational)
// - out_valid   out  1          stage DEPTH-1 holds a valid item (registered)
// - out_data    out  WIDTH      stage DEPTH-1 payload (registered)
// - out_ready   in   1          downstream accepts the item this cycle
// - flush_mask  in   DEPTH      bit i set: stage i holds no valid item after this edge
// - occupancy   out  OCC_W      number of valid stages (registered)
// BEHAVIOUR
// - Reset: all valid bits 0, all data regs 0; out_valid=0, out_data=0, occupancy=0; in_ready=1 the cycle after.
// - Ready chain: rdy[DEPTH]=out_ready; rdy[i] = !valid[i] | rdy[i+1]; in_ready = rdy[0].
// - Move: stage i loads from stage i-1 (or in_data for i=0) when rdy[i]=1.
// - Valid/data: valid[i] <= src_valid; data[i] <= src_data only when src_valid=1; data otherwise holds.
// - Bubble collapse: an empty stage always accepts, so gaps close while the output is stalled.
// - Hold: when rdy[i]=0, stage i keeps its valid bit and data.
// - Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
// - out_data is stable and out_valid stays 1 until the output transfer.
// - Latency: DEPTH cycles from input transfer to out_valid with no backpressure; throughput 1 item/cycle.
// - Flush: applies to the next-state value; valid[i] <= 0 if flush_mask[i]; overrides load and hold.
// - Flush, data: data[i] of a flushed stage is not cleared.
// - Flush, moving items: an item leaving stage i into an unflushed stage i+1 survives.
// - Flush, input: in_ready is not gated by flush; an input transfer into a flushed stage 0 is dropped.
// - Flush, output: an output transfer completes normally even if flush_mask[DEPTH-1]=1 on that edge.
// - Occupancy: next-state popcount of valid[DEPTH-1:0]; range 0..DEPTH; never wraps.
// - Full: occupancy=DEPTH and out_ready=0 gives in_ready=0.
// - Full with out_ready=1: in_ready=1 in the same cycle, so a simultaneous push and pop is accepted.
// - Empty: out_valid=0, so out_ready is ignored.
// - DEPTH=1: a single register; in_ready = !valid[0] | out_ready.
// - Reset mid-operation: all in-flight items are discarded and no output transfer completes on the reset edge.
// - Arithmetic: no data manipulation; payload passes bit-exact.
// CONFIGURATION
// - Macro PIPE_PERF_CNT_EN adds output ports stall_cnt[31:0] and flush_cnt[31:0].
// - stall_cnt: +1 per cycle with in_valid & !in_ready.
// - flush_cnt: +popcount of stages that are valid, or are being loaded with a valid item, and have flush_mask set.
// - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
// - Macro undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
// - DEPTH=4, out_ready=1; push 0x11,0x22,0x33 on consecutive cycles.
//   -> 0x11 at output 4 cycles after its push, then 0x22, 0x33 back-to-back; occupancy peaks at 3.
// - out_ready=0; push 6 items -> 4 accepted, occupancy=4, in_ready=0; raise out_ready -> drain in order, none lost.
// - Push A, idle 2 cycles, push B, out_ready=0 -> B collapses behind A; occupancy=2 with valid[3:2]=2'b11.
// - Full chain, out_ready=1, in_valid=1 -> one pop and one push per cycle; occupancy stays 4.
// - Stages hold items 1..4; flush_mask=4'b0011 -> only items in stages 2..3 reach the output.
// - Flush with PIPE_PERF_CNT_EN: flush_cnt equals the number of items killed.
// - Full chain, assert rst for 1 cycle -> next cycle out_valid=0, occupancy=0, out_data=0.
// - Reset with PIPE_PERF_CNT_EN: stall_cnt=0; 5 cycles blocked on a full chain -> stall_cnt=5.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Generic DEPTH-stage register chain with ready/valid backpressure, bubble collapse,
// per-stage flush and occupancy count. Define PIPE_PERF_CNT_EN for stall/flush counters.

module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid_nxt,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  // Flush wins over both load and hold; a flushed stage keeps its stale data.
  assign valid_nxt = flush ? 1'b0 : (ld ? src_valid : valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_nxt;
      if (ld && src_valid) data <= src_data;
    end
  end
endmodule

module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic [DEPTH-1:0] flush_mask,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
`endif
  output logic [OCC_W-1:0] occupancy
);
  logic [DEPTH-1:0]            vld_pipe;
  logic [DEPTH-1:0]            vld_nxt;
  logic [DEPTH-1:0]            src_vld;
  logic [DEPTH:0]              rdy;
  logic [DEPTH-1:0][WIDTH-1:0] data_pipe;
  logic [DEPTH-1:0][WIDTH-1:0] src_data;
  logic [OCC_W-1:0]            occ_nxt;

  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0];
  assign out_valid  = vld_pipe[DEPTH-1];
  assign out_data   = data_pipe[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // An empty stage always accepts, which is what closes bubbles under stall.
    assign rdy[i] = !vld_pipe[i] | rdy[i+1];
    if (i == 0) begin : g_head
      assign src_vld[i]  = in_valid;
      assign src_data[i] = in_data;
    end else begin : g_body
      assign src_vld[i]  = vld_pipe[i-1];
      assign src_data[i] = data_pipe[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ld        (rdy[i]),
      .flush     (flush_mask[i]),
      .src_valid (src_vld[i]),
      .src_data  (src_data[i]),
      .valid_nxt (vld_nxt[i]),
      .valid     (vld_pipe[i]),
      .data      (data_pipe[i])
    );
  end

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_nxt;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] flush_inc;
  logic [32:0] flush_sum;

  // A kill is any stage with flush set that holds, or is about to receive, a valid item.
  always_comb begin
    flush_inc = '0;
    for (int i = 0; i < DEPTH; i++)
      flush_inc = flush_inc + 32'(flush_mask[i] & (vld_pipe[i] | (rdy[i] & src_vld[i])));
  end
  assign flush_sum = {1'b0, flush_cnt} + {1'b0, flush_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      flush_cnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=4); directed scenarios plus a randomized
// run scored against a FIFO-level model (items accepted but not yet delivered).
`timescale 1ns/1ps
module tb_pipe_stage_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [DEPTH-1:0] flush_mask;
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush_mask (flush_mask),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .occupancy  (occupancy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_mask = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h exp 0", out_valid); else pass_cnt++;
    total++; if (out_data !== '0) $display("FAIL reset_out_data got %0h exp 0", out_data); else pass_cnt++;
    total++; if (occupancy !== '0) $display("FAIL reset_occupancy got %0d exp 0", occupancy); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0h exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_latency();
    logic [WIDTH-1:0] items [3];
    int peak = 0;
    items[0] = 32'h11; items[1] = 32'h22; items[2] = 32'h33;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 3);
      in_data  = (k < 3) ? items[k] : '0;
      tick();
      if (int'(occupancy) > peak) peak = int'(occupancy);
      total++;
      if (out_valid !== ((k >= 3) && (k <= 5)))
        $display("FAIL latency_valid k=%0d got %0h exp %0h", k, out_valid, (k >= 3) && (k <= 5));
      else pass_cnt++;
      if (k >= 3 && k <= 5) begin
        total++;
        if (out_data !== items[k-3]) $display("FAIL latency_data k=%0d got %0h exp %0h", k, out_data, items[k-3]);
        else pass_cnt++;
      end
    end
    total++; if (peak != 3) $display("FAIL latency_peak_occ got %0d exp 3", peak); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] q[$];
    int got = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      if (in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (q.size() != 4) $display("FAIL bp_accepted got %0d exp 4", q.size()); else pass_cnt++;
    total++; if (occupancy !== 3'd4) $display("FAIL bp_occupancy got %0d exp 4", occupancy); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %0h exp 0", in_ready); else pass_cnt++;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL bp_extra_item got %0h exp none", out_data);
        else if (out_data !== q[0]) $display("FAIL bp_drain_data got %0h exp %0h", out_data, q[0]);
        else pass_cnt++;
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      tick();
    end
    total++; if (got != 4) $display("FAIL bp_drain_count got %0d exp 4", got); else pass_cnt++;
  endtask

  task automatic test_collapse();
    logic [WIDTH-1:0] a, b;
    a = $urandom; b = $urandom;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 0) || (k == 3);
      in_data  = (k == 0) ? a : b;
      tick();
    end
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd2) $display("FAIL collapse_occ got %0d exp 2", occupancy); else pass_cnt++;
    total++; if (out_valid !== 1'b1 || out_data !== a) $display("FAIL collapse_head got %0h/%0h exp 1/%0h", out_valid, out_data, a); else pass_cnt++;
    // One pop: B must appear immediately, proving it sat directly behind A.
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== b) $display("FAIL collapse_second got %0h/%0h exp 1/%0h", out_valid, out_data, b); else pass_cnt++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL collapse_empty got %0h exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] q[$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = $urandom; q.push_back(in_data);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== q[0])
        $display("FAIL b2b_cycle k=%0d got rdy=%0h v=%0h d=%0h exp 1/1/%0h", k, in_ready, out_valid, out_data, q[0]);
      else pass_cnt++;
      void'(q.pop_front());
      q.push_back(in_data);
      tick();
      total++; if (occupancy !== 3'd4) $display("FAIL b2b_occ k=%0d got %0d exp 4", k, occupancy); else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [WIDTH-1:0] got[$];
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      tick();
    end
    in_valid = 1'b0; flush_mask = 4'b0011;
    tick();
    flush_mask = '0;
    total++; if (occupancy !== 3'd2) $display("FAIL flush_occ got %0d exp 2", occupancy); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
      tick();
    end
    total++;
    if (got.size() != 2 || got[0] !== 32'd1 || got[1] !== 32'd2)
      $display("FAIL flush_survivors got n=%0d first=%0h exp n=2 1,2", got.size(), (got.size() != 0) ? got[0] : 32'hx);
    else pass_cnt++;
`ifdef PIPE_PERF_CNT_EN
    total++; if (flush_cnt !== 32'd2) $display("FAIL flush_cnt_kill got %0d exp 2", flush_cnt); else pass_cnt++;
`endif
    // Input transfer into a flushed stage 0 is accepted but dropped.
    in_valid = 1'b1; in_data = 32'hDEAD; flush_mask = 4'b0001;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %0h exp 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0; flush_mask = '0;
    total++; if (occupancy !== '0) $display("FAIL flush_drop_occ got %0d exp 0", occupancy); else pass_cnt++;
    // Output transfer completes even with the last stage flushed on that edge.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    out_ready = 1'b1; flush_mask = 4'b1000;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h55) $display("FAIL flush_out_xfer got %0h/%0h exp 1/55", out_valid, out_data); else pass_cnt++;
    tick();
    flush_mask = '0;
    total++; if (occupancy !== '0 || out_valid !== 1'b0) $display("FAIL flush_out_after got %0d/%0h exp 0/0", occupancy, out_valid); else pass_cnt++;
`ifdef PIPE_PERF_CNT_EN
    total++; if (flush_cnt !== 32'd4) $display("FAIL flush_cnt_total got %0d exp 4", flush_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = $urandom | 32'h1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %0h exp 0", out_valid); else pass_cnt++;
    total++; if (occupancy !== '0) $display("FAIL midrst_occ got %0d exp 0", occupancy); else pass_cnt++;
    total++; if (out_data !== '0) $display("FAIL midrst_data got %0h exp 0", out_data); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %0h exp 1", in_ready); else pass_cnt++;
`ifdef PIPE_PERF_CNT_EN
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) $display("FAIL midrst_cnts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    total++; if (stall_cnt !== 32'd5) $display("FAIL stall_cnt got %0d exp 5", stall_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    int rdy_bias;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rdy_bias  = (n / 100) % 4;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) < rdy_bias);
      @(negedge clk);
      total++;
      if (in_ready !== ((q.size() < DEPTH) || out_ready))
        $display("FAIL rand_in_ready n=%0d got %0h exp %0h", n, in_ready, (q.size() < DEPTH) || out_ready);
      else pass_cnt++;
      if (out_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL rand_phantom n=%0d got %0h exp none", n, out_data);
        else if (out_data !== q[0]) $display("FAIL rand_data n=%0d got %0h exp %0h", n, out_data, q[0]);
        else pass_cnt++;
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
      total++;
      if (int'(occupancy) != q.size()) $display("FAIL rand_occ n=%0d got %0d exp %0d", n, occupancy, q.size());
      else pass_cnt++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_mask = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_collapse();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
